roi_capture_ctrl: RTL and testbench

Frame-capture scheduler between the pseudo-sensor VGA timing controller and the LeNet-5 input buffer. It samples a centred 224×224 window of the active raster, decimated by 8 to 28×28, and writes it into one bank of a two-bank (ping-pong) input RAM. It also tracks bank ownership between the raster producer and the CNN consumer with a valid/ack handshake. Frames are dropped and counted when no bank is free.

---
 rtl/pseudo_sensor_pkg.sv | 20 ++
 rtl/roi_window_sampler.sv | 71 +++++++
 rtl/roi_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_roi_capture_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_sensor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pseudo_sensor_pkg : shared ROI geometry and capture state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package pseudo_sensor_pkg;

  localparam int ROI_N      = 28;
  localparam int SCALE_LOG2 = 3;
  localparam int ROI_PIX    = ROI_N * ROI_N;
  localparam int IDX_W      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/roi_window_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// roi_window_sampler : ROI window / decimation test and raster index counter
// Rev 1.0
// ----------------------------------------------------------------------------
module roi_window_sampler
  import pseudo_sensor_pkg::*;
#(
  parameter int ROI_X0     = 208,
  parameter int ROI_Y0     = 128,
  parameter int ROI_N      = pseudo_sensor_pkg::ROI_N,
  parameter int SCALE_LOG2 = pseudo_sensor_pkg::SCALE_LOG2
) (
  input  logic                               p_clk,
  input  logic                               arst_p_n,
  input  logic                               de,
  input  logic [9:0]                         px,
  input  logic [8:0]                         py,
  input  logic                               idx_clr,
  input  logic                               idx_inc,
  output logic                               sample,
  output logic [pseudo_sensor_pkg::IDX_W-1:0] index
);

  localparam int         SPAN   = ROI_N << SCALE_LOG2;
  localparam logic [10:0] X_LO  = 11'(ROI_X0);
  localparam logic [10:0] X_HI  = 11'(ROI_X0 + SPAN);
  localparam logic [9:0]  Y_LO  = 10'(ROI_Y0);
  localparam logic [9:0]  Y_HI  = 10'(ROI_Y0 + SPAN);
  localparam logic [10:0] X_MSK = 11'((1 << SCALE_LOG2) - 1);
  localparam logic [9:0]  Y_MSK = 10'((1 << SCALE_LOG2) - 1);

  logic             de_d_q, de_d_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [10:0]      x_ext, x_off;
  logic [9:0]       y_ext, y_off;

  // de is delayed once so that it lines up with the registered px/py/pix
  always_comb begin
    de_d_d = de;
    x_ext  = {1'b0, px};
    y_ext  = {1'b0, py};
    x_off  = x_ext - X_LO;
    y_off  = y_ext - Y_LO;
    sample = de_d_q
             && (x_ext >= X_LO) && (x_ext < X_HI)
             && (y_ext >= Y_LO) && (y_ext < Y_HI)
             && ((x_off & X_MSK) == 11'd0)
             && ((y_off & Y_MSK) == 10'd0);
    index_d = index_q;
    if (idx_clr) begin
      index_d = '0;
    end else if (idx_inc) begin
      index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      de_d_q  <= 1'b0;
      index_q <= '0;
    end else begin
      de_d_q  <= de_d_d;
      index_q <= index_d;
    end
  end

  assign index = index_q;

endmodule
`default_nettype wire

// File: rtl/roi_capture_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// roi_capture_ctrl : ROI capture FSM, ping-pong bank ownership and drop count
// Rev 1.0
// ----------------------------------------------------------------------------
module roi_capture_ctrl
  import pseudo_sensor_pkg::*;
#(
  parameter int ROI_X0     = 208,
  parameter int ROI_Y0     = 128,
  parameter int ROI_N      = pseudo_sensor_pkg::ROI_N,
  parameter int SCALE_LOG2 = pseudo_sensor_pkg::SCALE_LOG2
) (
  input  logic        p_clk,
  input  logic        arst_p_n,
  input  logic        de,
  input  logic [9:0]  px,
  input  logic [8:0]  py,
  input  logic [7:0]  pix,
  input  logic        sof,
  input  logic        eof,
  input  logic        run,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frm_valid,
  output logic        frm_bank,
  input  logic        frm_ack,
  output logic        cap_busy,
  output logic [7:0]  drop_cnt
);

  localparam int FRAME_PIX = ROI_N * ROI_N;

  cap_state_e       state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [7:0]       drop_q, drop_d;
  logic             wr_en_q, wr_en_d;
  logic [10:0]      wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic             sample;
  logic             idx_clr;
  logic             wr_fire;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] idx_after;

  roi_window_sampler #(
    .ROI_X0     (ROI_X0),
    .ROI_Y0     (ROI_Y0),
    .ROI_N      (ROI_N),
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_sampler (
    .p_clk    (p_clk),
    .arst_p_n (arst_p_n),
    .de       (de),
    .px       (px),
    .py       (py),
    .idx_clr  (idx_clr),
    .idx_inc  (wr_fire),
    .sample   (sample),
    .index    (index)
  );

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    drop_d    = drop_q;
    idx_clr   = 1'b0;
    wr_fire   = (state_q == CAPT) && sample;
    // index as it will stand once a write coinciding with eof is counted
    idx_after = index + {{(IDX_W-1){1'b0}}, wr_fire};
    wr_en_d   = wr_fire;
    wr_addr_d = wr_fire ? {wr_bank_q, index} : wr_addr_q;
    wr_data_d = wr_fire ? pix : wr_data_q;

    if (frm_ack && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    case (state_q)
      IDLE: begin
        if (run) state_d = ARM;
      end
      ARM: begin
        if (sof) begin
          if (!run) begin
            state_d = IDLE;
          end else if (!full_q[wr_bank_q]) begin
            state_d = CAPT;
            idx_clr = 1'b1;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      CAPT: begin
        if (eof) begin
          state_d = run ? ARM : IDLE;
          // a truncated frame leaves its bank free for the next attempt
          if (idx_after == IDX_W'(FRAME_PIX)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      drop_q    <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 11'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frm_valid = full_q[rd_bank_q];
  assign frm_bank  = rd_bank_q;
  assign cap_busy  = (state_q == CAPT);
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_roi_capture_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_roi_capture_ctrl : directed self-checking bench for roi_capture_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_roi_capture_ctrl;

  logic        p_clk    = 1'b0;
  logic        arst_p_n = 1'b0;
  logic        de       = 1'b0;
  logic [9:0]  px       = '0;
  logic [8:0]  py       = '0;
  logic [7:0]  pix      = '0;
  logic        sof      = 1'b0;
  logic        eof      = 1'b0;
  logic        run      = 1'b0;
  logic        frm_ack  = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frm_valid;
  logic        frm_bank;
  logic        cap_busy;
  logic [7:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [10:0] q_addr[$];
  logic [7:0]  q_data[$];

  int   last_x = 0;
  int   last_y = 0;
  logic busy_mid, eof_pre, eof_post_valid, eof_post_bank, eof_post_busy;
  logic ack_post_valid, ack_post_bank;

  roi_capture_ctrl dut (
    .p_clk     (p_clk),
    .arst_p_n  (arst_p_n),
    .de        (de),
    .px        (px),
    .py        (py),
    .pix       (pix),
    .sof       (sof),
    .eof       (eof),
    .run       (run),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frm_valid (frm_valid),
    .frm_bank  (frm_bank),
    .frm_ack   (frm_ack),
    .cap_busy  (cap_busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 p_clk = ~p_clk;

  always @(negedge p_clk) begin
    if (arst_p_n && wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  function automatic logic [7:0] pixf(input int x, input int y);
    return 8'((x * 7 + y * 13) & 255);
  endfunction

  // number of logged writes that differ from the raster-order model for a bank
  function automatic int bad_writes(input logic bank);
    int n;
    logic [10:0] ea;
    logic [7:0]  ed;
    n = 0;
    for (int k = 0; k < q_addr.size(); k++) begin
      ea = {bank, 10'(k)};
      ed = pixf(208 + 8 * (k % 28), 128 + 8 * (k / 28));
      if (q_addr[k] !== ea || q_data[k] !== ed) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  // de/sof/eof describe this cycle's pixel; px/py/pix the previous one
  task automatic emit(input bit v, input int x, input int y, input bit s, input bit e, input bit a);
    px      = 10'(last_x);
    py      = 9'(last_y);
    pix     = pixf(last_x, last_y);
    de      = v;
    sof     = s;
    eof     = e;
    frm_ack = a;
    if (v) begin
      last_x = x;
      last_y = y;
    end
    tick();
    de      = 1'b0;
    sof     = 1'b0;
    eof     = 1'b0;
    frm_ack = 1'b0;
  endtask

  // compressed raster: only columns/rows around the window edges and phases
  task automatic frame(input bit shrt, input int ack_py, input int runoff_py, input bit abort);
    int  y_lo;
    int  y_hi;
    bit  first;
    y_lo  = shrt ? 128 : 120;
    y_hi  = shrt ? 128 : 353;
    first = 1'b1;
    for (int y = y_lo; y <= y_hi; y++) begin
      int xf;
      if (y == ack_py) begin
        emit(0, 0, 0, 0, 0, 1);
        ack_post_valid = frm_valid;
        ack_post_bank  = frm_bank;
      end
      if (y == runoff_py) run = 1'b0;
      if (y == 200) busy_mid = cap_busy;
      emit(1, 200, y, first, 0, 0);
      first = 1'b0;
      if (y >= 128 && y < 352 && ((y - 128) % 8) == 0) begin
        for (int c = 0; c < 28; c++) begin
          if (abort && y == 240 && c == 8) begin
            for (int b = 0; b < 3; b++) emit(0, 0, 0, 0, 0, 0);
            return;
          end
          emit(1, 207 + 8 * c, y, 0, 0, 0);
          emit(1, 208 + 8 * c, y, 0, 0, 0);
        end
        xf = 432;
      end else begin
        xf = 208;
      end
      if (y == y_hi) begin
        eof_pre = frm_valid;
        emit(1, xf, y, 0, 1, 0);
        eof_post_valid = frm_valid;
        eof_post_bank  = frm_bank;
        eof_post_busy  = cap_busy;
      end else begin
        emit(1, xf, y, 0, 0, 0);
      end
      emit(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    arst_p_n = 1'b0;
    run      = 1'b0;
    de       = 1'b0;
    frm_ack  = 1'b0;
    tick();
    tick();
    arst_p_n = 1'b1;
    tick();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic start_run();
    run = 1'b1;
    repeat (3) tick();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    arst_p_n = 1'b0;
    #2;
    n_chk++;
    if ({wr_en, wr_addr, wr_data, frm_valid, frm_bank, cap_busy, drop_cnt} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h required 0",
               {wr_en, wr_addr, wr_data, frm_valid, frm_bank, cap_busy, drop_cnt});
    end
    do_reset();
    n_chk++;
    if ({frm_valid, cap_busy, drop_cnt} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %0h required 0", {frm_valid, cap_busy, drop_cnt});
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    start_run();
    frame(0, -1, -1, 0);
    n_chk++;
    if (q_addr.size() != 784) begin
      n_fail++; $display("FAIL single_count: got %0d required 784", q_addr.size());
    end
    n_chk++;
    if (q_addr[0] !== 11'h000 || q_data[0] !== pixf(208, 128)) begin
      n_fail++; $display("FAIL single_first: got %0h/%0h required 0/%0h", q_addr[0], q_data[0], pixf(208, 128));
    end
    n_chk++;
    if (q_addr[q_addr.size()-1] !== 11'h30F || q_data[q_data.size()-1] !== pixf(424, 344)) begin
      n_fail++; $display("FAIL single_last: got %0h/%0h required 30f/%0h",
                         q_addr[q_addr.size()-1], q_data[q_data.size()-1], pixf(424, 344));
    end
    n_chk++;
    if (bad_writes(1'b0) != 0) begin
      n_fail++; $display("FAIL single_content: got %0d bad writes required 0", bad_writes(1'b0));
    end
    n_chk++;
    if ({busy_mid, eof_pre} !== 2'b10) begin
      n_fail++; $display("FAIL single_busy_pre: got busy=%b valid=%b required 1/0", busy_mid, eof_pre);
    end
    n_chk++;
    if ({eof_post_valid, eof_post_bank, eof_post_busy} !== 3'b100) begin
      n_fail++; $display("FAIL single_after_eof: got valid=%b bank=%b busy=%b required 1/0/0",
                         eof_post_valid, eof_post_bank, eof_post_busy);
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    start_run();
    emit(0, 0, 0, 0, 0, 1);
    tick();
    n_chk++;
    if ({frm_valid, frm_bank} !== 2'b00) begin
      n_fail++; $display("FAIL spurious_ack: got valid=%b bank=%b required 0/0", frm_valid, frm_bank);
    end
    frame(0, -1, -1, 0);
    n_chk++;
    if (q_addr.size() != 784 || bad_writes(1'b0) != 0) begin
      n_fail++; $display("FAIL spurious_frame: got %0d writes, %0d bad required 784/0", q_addr.size(), bad_writes(1'b0));
    end
    n_chk++;
    if ({eof_post_valid, eof_post_bank} !== 2'b10) begin
      n_fail++; $display("FAIL spurious_bank: got valid=%b bank=%b required 1/0", eof_post_valid, eof_post_bank);
    end
  endtask

  task automatic test_ping_pong();
    do_reset();
    start_run();
    for (int f = 0; f < 3; f++) begin
      logic exp_bank;
      exp_bank = 1'(f % 2);
      q_addr.delete();
      q_data.delete();
      frame(0, (f == 0) ? -1 : 240, -1, 0);
      n_chk++;
      if (q_addr.size() != 784 || bad_writes(exp_bank) != 0) begin
        n_fail++; $display("FAIL pingpong_frame%0d: got %0d writes, %0d bad for bank %0d required 784/0",
                           f, q_addr.size(), bad_writes(exp_bank), exp_bank);
      end
      n_chk++;
      if ({eof_post_valid, eof_post_bank} !== {1'b1, exp_bank}) begin
        n_fail++; $display("FAIL pingpong_eof%0d: got valid=%b bank=%b required 1/%b",
                           f, eof_post_valid, eof_post_bank, exp_bank);
      end
      if (f > 0) begin
        n_chk++;
        if ({ack_post_valid, ack_post_bank} !== {1'b0, exp_bank}) begin
          n_fail++; $display("FAIL pingpong_ack%0d: got valid=%b bank=%b required 0/%b",
                             f, ack_post_valid, ack_post_bank, exp_bank);
        end
      end
    end
    n_chk++;
    if (drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL pingpong_drop: got %0d required 0", drop_cnt);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    start_run();
    for (int f = 0; f < 2; f++) begin
      q_addr.delete();
      q_data.delete();
      frame(0, -1, -1, 0);
      n_chk++;
      if (q_addr.size() != 784 || bad_writes(1'(f)) != 0) begin
        n_fail++; $display("FAIL overrun_fill%0d: got %0d writes, %0d bad required 784/0",
                           f, q_addr.size(), bad_writes(1'(f)));
      end
    end
    q_addr.delete();
    q_data.delete();
    frame(1, -1, -1, 0);
    frame(1, -1, -1, 0);
    n_chk++;
    if (q_addr.size() != 0) begin
      n_fail++; $display("FAIL overrun_no_writes: got %0d required 0", q_addr.size());
    end
    n_chk++;
    if (drop_cnt !== 8'd2) begin
      n_fail++; $display("FAIL overrun_drop: got %0d required 2", drop_cnt);
    end
    emit(0, 0, 0, 0, 0, 1);
    n_chk++;
    if ({frm_valid, frm_bank} !== 2'b11) begin
      n_fail++; $display("FAIL overrun_ack: got valid=%b bank=%b required 1/1", frm_valid, frm_bank);
    end
    tick();
    frame(0, -1, -1, 0);
    n_chk++;
    if (q_addr.size() != 784 || bad_writes(1'b0) != 0) begin
      n_fail++; $display("FAIL overrun_resume: got %0d writes, %0d bad required 784/0", q_addr.size(), bad_writes(1'b0));
    end
    n_chk++;
    if (drop_cnt !== 8'd2) begin
      n_fail++; $display("FAIL overrun_drop_hold: got %0d required 2", drop_cnt);
    end
  endtask

  task automatic test_run_drop();
    do_reset();
    start_run();
    frame(0, -1, 200, 0);
    n_chk++;
    if (q_addr.size() != 784 || bad_writes(1'b0) != 0) begin
      n_fail++; $display("FAIL rundrop_frame: got %0d writes, %0d bad required 784/0", q_addr.size(), bad_writes(1'b0));
    end
    n_chk++;
    if ({eof_post_valid, eof_post_busy} !== 2'b10) begin
      n_fail++; $display("FAIL rundrop_eof: got valid=%b busy=%b required 1/0", eof_post_valid, eof_post_busy);
    end
    q_addr.delete();
    q_data.delete();
    frame(1, -1, -1, 0);
    n_chk++;
    if (q_addr.size() != 0 || drop_cnt !== 8'd0 || cap_busy !== 1'b0) begin
      n_fail++; $display("FAIL rundrop_idle: got %0d writes drop=%0d busy=%b required 0/0/0",
                         q_addr.size(), drop_cnt, cap_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    start_run();
    frame(0, -1, -1, 1);
    n_chk++;
    if (q_addr.size() != 400) begin
      n_fail++; $display("FAIL midreset_progress: got %0d writes required 400", q_addr.size());
    end
    arst_p_n = 1'b0;
    #1;
    n_chk++;
    if ({wr_en, wr_addr, wr_data, frm_valid, frm_bank, cap_busy, drop_cnt} !== 31'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %0h required 0",
               {wr_en, wr_addr, wr_data, frm_valid, frm_bank, cap_busy, drop_cnt});
    end
    tick();
    tick();
    arst_p_n = 1'b1;
    repeat (3) tick();
    q_addr.delete();
    q_data.delete();
    frame(0, -1, -1, 0);
    n_chk++;
    if (q_addr.size() != 784 || bad_writes(1'b0) != 0) begin
      n_fail++; $display("FAIL midreset_next: got %0d writes, %0d bad required 784/0", q_addr.size(), bad_writes(1'b0));
    end
    n_chk++;
    if ({eof_post_valid, eof_post_bank} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_bank: got valid=%b bank=%b required 1/0", eof_post_valid, eof_post_bank);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_spurious_ack();
    test_ping_pong();
    test_overrun();
    test_run_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
